// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, flag forwarding and hazard/stall control for the ID stage.
// Resolves ID operands from EX/MEM and freezes the front end on load-use and CBZ hazards.
module fwd_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [63:0]      id_rd1,
    input  logic [63:0]      id_rd2,
    input  logic             id_is_cbz,
    input  logic             id_is_bcond,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_flagen,
    input  logic [63:0]      ex_result,
    input  logic [3:0]       ex_flags,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [63:0]      mem_result,
    input  logic [63:0]      mem_rdata,
    output logic [63:0]      opnd_a,
    output logic [63:0]      opnd_b,
    output logic [3:0]       flags_out,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, STALL2, STALL1} state_t;

    state_t     state, state_next;
    logic [3:0] flag_reg;
    logic       stall_c;

    // B.cond only consumes flags_out; the decode bit itself needs no logic here
    logic       unused_bcond;
    assign unused_bcond = id_is_bcond;

    // XZR (X31) never matches a producer, so it always reads the register file value
    logic rn_ex_alu, rn_ex_load, rn_mem;
    logic rm_ex_alu, rm_ex_load, rm_mem;

    assign rn_ex_alu  = (id_rn != 5'd31) && ex_regwrite && !ex_memread && (ex_wreg == id_rn);
    assign rn_ex_load = (id_rn != 5'd31) && ex_regwrite &&  ex_memread && (ex_wreg == id_rn);
    assign rn_mem     = (id_rn != 5'd31) && mem_regwrite && (mem_wreg == id_rn);
    assign rm_ex_alu  = (id_rm != 5'd31) && ex_regwrite && !ex_memread && (ex_wreg == id_rm);
    assign rm_ex_load = (id_rm != 5'd31) && ex_regwrite &&  ex_memread && (ex_wreg == id_rm);
    assign rm_mem     = (id_rm != 5'd31) && mem_regwrite && (mem_wreg == id_rm);

    always_comb begin
        opnd_a = id_rd1;
        if (rn_ex_alu)
            opnd_a = ex_result;
        else if (rn_mem)
            opnd_a = mem_memread ? mem_rdata : mem_result;
    end

    always_comb begin
        opnd_b = id_rd2;
        if (rm_ex_alu)
            opnd_b = ex_result;
        else if (rm_mem)
            opnd_b = mem_memread ? mem_rdata : mem_result;
    end

    logic load_use, cbz_alu, cbz_load, hazard;

    assign load_use = (id_rn_used && rn_ex_load) || (id_rm_used && rm_ex_load);
    assign cbz_alu  = id_is_cbz && rn_ex_alu;
    assign cbz_load = id_is_cbz && rn_ex_load;
    assign hazard   = load_use || cbz_alu || cbz_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // STALL1 re-checks the advanced pipeline, so back-to-back hazards skip RUN
    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            RUN, STALL1: begin
                if (cbz_load) begin
                    state_next = STALL2;
                    stall_c    = 1'b1;
                end else if (hazard) begin
                    state_next = STALL1;
                    stall_c    = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            STALL2: begin
                state_next = STALL1;
                stall_c    = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    assign stall  = stall_c;
    assign bubble = stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flag_reg <= 4'b0000;
        else if (ex_flagen)
            flag_reg <= ex_flags;
    end

    assign flags_out = ex_flagen ? ex_flags : flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_c && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table plus multi-cycle sequences,
// expected values queued at drive time and compared against the DUT half a cycle later.
module tb_fwd_hazard_unit;

    localparam int          CW   = 4;
    localparam logic [63:0] RD1  = 64'h1111_0000_0000_1111;
    localparam logic [63:0] RD2  = 64'h2222_0000_0000_2222;
    localparam logic [63:0] EXR  = 64'h0000_0000_0000_0055;
    localparam logic [63:0] MEMR = 64'hAAAA_0000_0000_AAAA;
    localparam logic [63:0] MEMD = 64'hDDDD_0000_0000_DDDD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rn, id_rm, ex_wreg, mem_wreg;
    logic          id_rn_used, id_rm_used, id_is_cbz, id_is_bcond;
    logic [63:0]   id_rd1, id_rd2, ex_result, mem_result, mem_rdata;
    logic          ex_regwrite, ex_memread, ex_flagen, mem_regwrite, mem_memread;
    logic [3:0]    ex_flags;
    logic [63:0]   opnd_a, opnd_b;
    logic [3:0]    flags_out;
    logic          stall, bubble;
    logic [CW-1:0] stall_count;

    fwd_hazard_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_is_cbz(id_is_cbz), .id_is_bcond(id_is_bcond),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_flagen(ex_flagen), .ex_result(ex_result), .ex_flags(ex_flags),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_result(mem_result), .mem_rdata(mem_rdata),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .flags_out(flags_out),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rn, rm;
        logic        rn_used, rm_used, is_cbz;
        logic [4:0]  ex_wreg;
        logic        ex_rw, ex_mr;
        logic [4:0]  mem_wreg;
        logic        mem_rw, mem_mr;
        logic [63:0] exp_a, exp_b;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        string         name;
        logic [63:0]   a, b;
        logic [3:0]    flags;
        logic          stall;
        logic [CW-1:0] count;
    } exp_t;

    exp_t          sb[$];
    vec_t          tbl[$];
    int            compared   = 0;
    int            mismatched = 0;
    logic [CW-1:0] expCount;
    logic [3:0]    flagReg;

    function automatic vec_t mkv(string name, int rn, int rm, int rnu, int rmu, int cbz,
                                 int exw, int exrw, int exmr, int memw, int memrw, int memmr,
                                 logic [63:0] ea, logic [63:0] eb, int est);
        vec_t v;
        v.name = name;
        v.rn = rn[4:0];  v.rm = rm[4:0];
        v.rn_used = rnu[0];  v.rm_used = rmu[0];  v.is_cbz = cbz[0];
        v.ex_wreg = exw[4:0];  v.ex_rw = exrw[0];  v.ex_mr = exmr[0];
        v.mem_wreg = memw[4:0];  v.mem_rw = memrw[0];  v.mem_mr = memmr[0];
        v.exp_a = ea;  v.exp_b = eb;  v.exp_stall = est[0];
        return v;
    endfunction

    function automatic vec_t idle(string name);
        return mkv(name, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD1, RD2, 0);
    endfunction

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what the DUT should show
    task automatic applyStimulus(vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        id_rn = v.rn;  id_rm = v.rm;  id_rn_used = v.rn_used;  id_rm_used = v.rm_used;
        id_is_cbz = v.is_cbz;
        ex_wreg = v.ex_wreg;  ex_regwrite = v.ex_rw;  ex_memread = v.ex_mr;
        mem_wreg = v.mem_wreg;  mem_regwrite = v.mem_rw;  mem_memread = v.mem_mr;
        e.name  = v.name;
        e.a     = v.exp_a;
        e.b     = v.exp_b;
        e.flags = ex_flagen ? ex_flags : flagReg;
        e.stall = v.exp_stall;
        e.count = expCount;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp({e.name, ".opnd_a"}, opnd_a, e.a);
        cmp({e.name, ".opnd_b"}, opnd_b, e.b);
        cmp({e.name, ".flags"}, {60'd0, flags_out}, {60'd0, e.flags});
        cmp({e.name, ".stall"}, {63'd0, stall}, {63'd0, e.stall});
        cmp({e.name, ".bubble"}, {63'd0, bubble}, {63'd0, e.stall});
        cmp({e.name, ".count"}, {{(64-CW){1'b0}}, stall_count}, {{(64-CW){1'b0}}, e.count});
    endtask

    // One full cycle, then advance the bench's own flag and counter model past the edge
    task automatic runVec(vec_t v);
        applyStimulus(v);
        checkOutput();
        if (v.exp_stall && expCount != {CW{1'b1}})
            expCount = expCount + 1'b1;
        if (ex_flagen)
            flagReg = ex_flags;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        id_rn = 5'd1;  id_rm = 5'd2;  id_rn_used = 1'b0;  id_rm_used = 1'b0;
        id_rd1 = RD1;  id_rd2 = RD2;  id_is_cbz = 1'b0;  id_is_bcond = 1'b0;
        ex_wreg = 5'd0;  ex_regwrite = 1'b0;  ex_memread = 1'b0;  ex_flagen = 1'b0;
        ex_result = EXR;  ex_flags = 4'b0000;
        mem_wreg = 5'd0;  mem_regwrite = 1'b0;  mem_memread = 1'b0;
        mem_result = MEMR;  mem_rdata = MEMD;
        expCount = '0;
        flagReg  = 4'b0000;

        repeat (2) @(posedge clk);
        #2;
        cmp("reset.stall", {63'd0, stall}, 64'd0);
        cmp("reset.count", {{(64-CW){1'b0}}, stall_count}, 64'd0);
        cmp("reset.flags", {60'd0, flags_out}, 64'd0);
        rst_n = 1'b1;

        tbl.push_back(mkv("no_match",     1,  2, 1, 1, 0,  9, 1, 0, 10, 1, 0, RD1,  RD2,  0));
        tbl.push_back(mkv("ex_fwd_a",     3,  2, 1, 1, 0,  3, 1, 0, 10, 1, 0, EXR,  RD2,  0));
        tbl.push_back(mkv("ex_fwd_b",     1,  4, 1, 1, 0,  4, 1, 0, 10, 1, 0, RD1,  EXR,  0));
        tbl.push_back(mkv("mem_alu_a",    6,  2, 1, 1, 0,  9, 1, 0,  6, 1, 0, MEMR, RD2,  0));
        tbl.push_back(mkv("mem_load_b",   1,  6, 1, 1, 0,  9, 1, 0,  6, 1, 1, RD1,  MEMD, 0));
        tbl.push_back(mkv("ex_over_mem",  8,  8, 1, 1, 0,  8, 1, 0,  8, 1, 0, EXR,  EXR,  0));
        tbl.push_back(mkv("xzr_both",    31, 31, 1, 1, 0, 31, 1, 0, 31, 1, 0, RD1,  RD2,  0));
        tbl.push_back(mkv("ex_nowrite",   3,  2, 1, 1, 0,  3, 0, 0,  3, 1, 0, MEMR, RD2,  0));
        tbl.push_back(mkv("mem_nowrite",  6,  2, 1, 1, 0,  9, 1, 0,  6, 0, 1, RD1,  RD2,  0));
        tbl.push_back(mkv("unused_src",   5,  2, 0, 1, 0,  5, 1, 1,  5, 1, 0, MEMR, RD2,  0));
        tbl.push_back(mkv("xzr_load",     1, 31, 1, 1, 0, 31, 1, 1,  9, 1, 0, RD1,  RD2,  0));
        tbl.push_back(mkv("cbz_nomatch",  4,  2, 1, 0, 1,  5, 1, 0,  9, 1, 0, RD1,  RD2,  0));
        tbl.push_back(mkv("cbz_rm_load",  4,  9, 1, 0, 1,  9, 1, 1, 10, 0, 0, RD1,  RD2,  0));
        for (int i = 0; i < tbl.size(); i++)
            runVec(tbl[i]);

        // Load-use on X5: exactly one stall, then the load data arrives from MEM
        runVec(mkv("lu_detect",  2, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, RD1, RD2,  1));
        runVec(mkv("lu_release", 2, 5, 0, 1, 0, 0, 0, 0, 5, 1, 1, RD1, MEMD, 0));
        runVec(idle("lu_after"));

        // CBZ on a load result: two stalls before the data is usable
        runVec(mkv("cbzld_detect", 7, 2, 1, 0, 1, 7, 1, 1, 0, 0, 0, RD1,  RD2, 1));
        runVec(mkv("cbzld_hold",   7, 2, 1, 0, 1, 0, 0, 0, 7, 1, 1, MEMD, RD2, 1));
        runVec(mkv("cbzld_go",     7, 2, 1, 0, 1, 0, 0, 0, 7, 1, 1, MEMD, RD2, 0));

        // CBZ on an ALU result: one stall
        runVec(mkv("cbz_detect",  4, 2, 1, 0, 1, 4, 1, 0, 0, 0, 0, EXR,  RD2, 1));
        runVec(mkv("cbz_go",      4, 2, 1, 0, 1, 0, 0, 0, 4, 1, 0, MEMR, RD2, 0));

        // A fresh CBZ-load seen in STALL1 goes straight to STALL2
        runVec(mkv("re_lu",     1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, RD1,  RD2,  1));
        runVec(mkv("re_cbzld",  3, 5, 1, 1, 1, 3, 1, 1, 5, 1, 1, RD1,  MEMD, 1));
        runVec(mkv("re_stall2", 3, 2, 1, 0, 1, 0, 0, 0, 3, 1, 1, MEMD, RD2,  1));
        runVec(mkv("re_done",   3, 2, 1, 0, 1, 0, 0, 0, 3, 1, 1, MEMD, RD2,  0));

        // XZR read with a pending EX write to X31
        id_rd2 = 64'd0;
        runVec(mkv("xzr_zero", 3, 31, 0, 1, 0, 31, 1, 0, 0, 0, 0, RD1, 64'd0, 0));
        id_rd2 = RD2;

        // Live flags in EX, then held flags from the register
        id_is_bcond = 1'b1;
        ex_flagen = 1'b1;  ex_flags = 4'b0100;
        runVec(idle("flags_live"));
        ex_flagen = 1'b0;  ex_flags = 4'b1011;
        runVec(idle("flags_held"));
        ex_flagen = 1'b1;  ex_flags = 4'b1011;
        runVec(idle("flags_new"));
        ex_flagen = 1'b0;  ex_flags = 4'b0000;
        id_is_bcond = 1'b0;

        // Continuous load-use hazards drive the narrow counter into saturation
        for (int i = 0; i < 18; i++)
            runVec(mkv("sat", 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, RD1, RD2, 1));
        runVec(idle("sat_end"));

        // Reset asserted while the FSM sits in STALL2
        runVec(mkv("rst_cbzld", 7, 2, 1, 0, 1, 7, 1, 1, 0, 0, 0, RD1, RD2, 1));
        v = mkv("rst_stall2", 7, 2, 1, 0, 1, 0, 0, 0, 7, 1, 1, MEMD, RD2, 1);
        applyStimulus(v);
        checkOutput();
        rst_n = 1'b0;
        #1;
        cmp("rst_mid.stall", {63'd0, stall}, 64'd0);
        cmp("rst_mid.count", {{(64-CW){1'b0}}, stall_count}, 64'd0);
        cmp("rst_mid.flags", {60'd0, flags_out}, 64'd0);
        expCount = '0;
        flagReg  = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        runVec(mkv("rst_after", 7, 2, 1, 0, 1, 0, 0, 0, 7, 1, 1, MEMD, RD2, 0));
        runVec(mkv("rst_lu",    2, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, RD1,  RD2, 1));
        runVec(idle("rst_lu_done"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
